// File: rtl/rgmii_rx_ctrl.sv
// RGMII receive controller: decodes IDDR Q1/Q2 nibbles into bytes, strips the
// preamble/SFD and streams frame bytes with last/error flags and frame counters.
module rgmii_rx_ctrl #(
  parameter int RST_CYCLES   = 16,
  parameter int MAX_PREAMBLE = 7
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [4:0]  q1,
  input  logic [4:0]  q2,
  output logic        iddr_rst,
  output logic        iddr_ce,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  output logic        m_error,
  output logic [15:0] frame_count,
  output logic [15:0] err_count
);

  localparam int HCNT_W = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int PCNT_W = $clog2(MAX_PREAMBLE + 1);
  localparam logic [HCNT_W-1:0] HOLD_LAST = HCNT_W'(RST_CYCLES - 1);
  localparam logic [PCNT_W-1:0] PCNT_MAX  = PCNT_W'(MAX_PREAMBLE);
  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  typedef enum logic [2:0] {
    S_HOLD     = 3'd0,
    S_IDLE     = 3'd1,
    S_PREAMBLE = 3'd2,
    S_DATA     = 3'd3,
    S_DROP     = 3'd4
  } state_e;

  state_e state_q, state_d;

  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic              hold_full_q, hold_full_d;
  logic [7:0]        hold_data_q, hold_data_d;
  logic              sticky_q, sticky_d;
  logic [7:0]        m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic              m_error_q, m_error_d;
  logic              iddr_rst_q, iddr_rst_d;
  logic              iddr_ce_q, iddr_ce_d;
  logic [15:0]       frame_count_q, frame_count_d;
  logic [15:0]       err_count_q, err_count_d;
  logic              frame_inc, err_inc;

  // Per-cycle decode: RX_CTL carries DV on the rising edge and DV^ER on the falling edge
  logic       dv, er;
  logic [7:0] rx_byte;
  logic       is_pre, is_sfd;

  assign dv      = q1[4];
  assign er      = q1[4] ^ q2[4];
  assign rx_byte = {q2[3:0], q1[3:0]};
  assign is_pre  = (rx_byte == PRE_BYTE);
  assign is_sfd  = (rx_byte == SFD_BYTE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_HOLD;
      hcnt_q        <= '0;
      pcnt_q        <= '0;
      hold_full_q   <= 1'b0;
      sticky_q      <= 1'b0;
      m_data_q      <= 8'h00;
      m_valid_q     <= 1'b0;
      m_last_q      <= 1'b0;
      m_error_q     <= 1'b0;
      iddr_rst_q    <= 1'b1;
      iddr_ce_q     <= 1'b0;
      frame_count_q <= 16'h0000;
      err_count_q   <= 16'h0000;
    end else begin
      state_q       <= state_d;
      hcnt_q        <= hcnt_d;
      pcnt_q        <= pcnt_d;
      hold_full_q   <= hold_full_d;
      sticky_q      <= sticky_d;
      m_data_q      <= m_data_d;
      m_valid_q     <= m_valid_d;
      m_last_q      <= m_last_d;
      m_error_q     <= m_error_d;
      iddr_rst_q    <= iddr_rst_d;
      iddr_ce_q     <= iddr_ce_d;
      frame_count_q <= frame_count_d;
      err_count_q   <= err_count_d;
    end
  end

  // The held byte is only observed while hold_full_q is set, so it needs no reset
  always_ff @(posedge clock) begin
    hold_data_q <= hold_data_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_HOLD: begin
        if (hcnt_q == HOLD_LAST) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (enable && dv) state_d = is_pre ? S_PREAMBLE : S_DROP;
      end
      S_PREAMBLE: begin
        if (!dv)                               state_d = S_IDLE;
        else if (is_sfd)                       state_d = S_DATA;
        else if (is_pre && (pcnt_q < PCNT_MAX)) state_d = S_PREAMBLE;
        else                                   state_d = S_DROP;
      end
      S_DATA: begin
        if (!dv) state_d = S_IDLE;
      end
      S_DROP: begin
        if (!dv) state_d = S_IDLE;
      end
      default: state_d = S_HOLD;
    endcase
  end

  always_comb begin
    hcnt_d      = hcnt_q;
    pcnt_d      = pcnt_q;
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    sticky_d    = sticky_q;
    m_data_d    = m_data_q;
    m_valid_d   = 1'b0;
    m_last_d    = 1'b0;
    m_error_d   = 1'b0;
    frame_inc   = 1'b0;
    err_inc     = 1'b0;
    case (state_q)
      S_HOLD: begin
        hcnt_d = (hcnt_q == HOLD_LAST) ? '0 : hcnt_q + 1'b1;
      end
      S_IDLE: begin
        hold_full_d = 1'b0;
        if (enable && dv) begin
          if (is_pre) pcnt_d = PCNT_W'(1);
          else        err_inc = 1'b1;
        end
      end
      S_PREAMBLE: begin
        if (dv) begin
          if (is_sfd)                             sticky_d = 1'b0;
          else if (is_pre && (pcnt_q < PCNT_MAX)) pcnt_d   = pcnt_q + 1'b1;
          else                                    err_inc  = 1'b1;
        end
      end
      S_DATA: begin
        if (dv) begin
          // One-byte skid so the final byte can be tagged once DV falls
          hold_data_d = rx_byte;
          hold_full_d = 1'b1;
          if (er) sticky_d = 1'b1;
          if (hold_full_q) begin
            m_valid_d = 1'b1;
            m_data_d  = hold_data_q;
          end
        end else begin
          hold_full_d = 1'b0;
          if (hold_full_q) begin
            m_valid_d = 1'b1;
            m_last_d  = 1'b1;
            m_error_d = sticky_q;
            m_data_d  = hold_data_q;
            if (sticky_q) err_inc   = 1'b1;
            else          frame_inc = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign iddr_rst_d    = (state_d == S_HOLD);
  assign iddr_ce_d     = (state_d != S_HOLD);
  assign frame_count_d = frame_count_q + {15'd0, frame_inc};
  assign err_count_d   = (err_inc && (err_count_q != 16'hFFFF)) ? err_count_q + 16'd1
                                                                 : err_count_q;

  assign iddr_rst    = iddr_rst_q;
  assign iddr_ce     = iddr_ce_q;
  assign m_data      = m_data_q;
  assign m_valid     = m_valid_q;
  assign m_last      = m_last_q;
  assign m_error     = m_error_q;
  assign frame_count = frame_count_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_rgmii_rx_ctrl.sv
// Scoreboard bench for rgmii_rx_ctrl: directed frames push expected beats,
// a negedge monitor pops and compares every emitted beat.
module tb_rgmii_rx_ctrl;

  logic        clock;
  logic        reset_n;
  logic        enable;
  logic [4:0]  q1;
  logic [4:0]  q2;
  logic        iddr_rst;
  logic        iddr_ce;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_error;
  logic [15:0] frame_count;
  logic [15:0] err_count;

  int n_pass  = 0;
  int n_total = 0;
  logic [9:0] sb[$];
  logic [9:0] mon_exp;

  rgmii_rx_ctrl #(.RST_CYCLES(16), .MAX_PREAMBLE(7)) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .q1(q1), .q2(q2),
    .iddr_rst(iddr_rst), .iddr_ce(iddr_ce), .m_data(m_data), .m_valid(m_valid),
    .m_last(m_last), .m_error(m_error), .frame_count(frame_count), .err_count(err_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %0h required %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    q1 = 5'h00;
    q2 = 5'h00;
    for (int i = 0; i < n; i++) tick();
  endtask

  // q2[4] carries DV^ER, so an errored byte drops the falling-edge CTL bit
  task automatic tx(input logic [7:0] b, input logic e);
    q1 = {1'b1, b[3:0]};
    q2 = {~e, b[7:4]};
    tick();
  endtask

  task automatic preamble(input int n);
    for (int i = 0; i < n; i++) tx(8'h55, 1'b0);
    tx(8'hD5, 1'b0);
  endtask

  task automatic expect_beat(input logic [7:0] d, input logic l, input logic e);
    sb.push_back({d, l, e});
  endtask

  always @(negedge clock) begin
    if (reset_n) begin
      if (m_valid) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_beat: actual data=%h last=%b err=%b required no beat",
                   m_data, m_last, m_error);
        end else begin
          mon_exp = sb.pop_front();
          chk("beat{data,last,err}", 32'({m_data, m_last, m_error}), 32'(mon_exp));
        end
      end else if (m_last || m_error) begin
        chk("flags_idle", 32'({m_last, m_error}), 32'd0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required $finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] hold_frame [6];

  initial begin
    hold_frame = '{8'h55, 8'h55, 8'h55, 8'hD5, 8'h01, 8'h02};
    reset_n = 1'b0;
    enable  = 1'b1;
    q1 = 5'h00;
    q2 = 5'h00;
    tick(); tick(); tick();
    chk("rst_iddr_rst", 32'(iddr_rst), 32'd1);
    chk("rst_iddr_ce", 32'(iddr_ce), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'h00);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_flags", 32'({m_last, m_error}), 32'd0);
    chk("rst_frame_count", 32'(frame_count), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);

    // Reset release; a frame driven during HOLD must vanish
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i < 6) begin
        q1 = {1'b1, hold_frame[i][3:0]};
        q2 = {1'b1, hold_frame[i][7:4]};
      end else begin
        q1 = 5'h00;
        q2 = 5'h00;
      end
      tick();
      chk("hold_iddr_rst", 32'(iddr_rst), 32'(i != 15));
      chk("hold_iddr_ce", 32'(iddr_ce), 32'(i == 15));
    end
    idle(3);
    chk("hold_err_count", 32'(err_count), 32'd0);
    chk("hold_frame_count", 32'(frame_count), 32'd0);

    // Good frame
    expect_beat(8'h01, 1'b0, 1'b0);
    expect_beat(8'h02, 1'b0, 1'b0);
    expect_beat(8'h03, 1'b1, 1'b0);
    preamble(7);
    tx(8'h01, 1'b0); tx(8'h02, 1'b0); tx(8'h03, 1'b0);
    idle(4);
    chk("good_frame_count", 32'(frame_count), 32'd1);
    chk("good_err_count", 32'(err_count), 32'd0);

    // ER on byte 0x02
    expect_beat(8'h01, 1'b0, 1'b0);
    expect_beat(8'h02, 1'b0, 1'b0);
    expect_beat(8'h03, 1'b1, 1'b1);
    preamble(7);
    tx(8'h01, 1'b0); tx(8'h02, 1'b1); tx(8'h03, 1'b0);
    idle(4);
    chk("er_frame_count", 32'(frame_count), 32'd1);
    chk("er_err_count", 32'(err_count), 32'd1);

    // Eight preamble bytes: dropped, then a good frame recovers
    preamble(8);
    tx(8'h01, 1'b0); tx(8'h02, 1'b0);
    idle(3);
    chk("badpre_err_count", 32'(err_count), 32'd2);
    expect_beat(8'hA5, 1'b0, 1'b0);
    expect_beat(8'h5A, 1'b1, 1'b0);
    preamble(7);
    tx(8'hA5, 1'b0); tx(8'h5A, 1'b0);
    idle(4);
    chk("recover_frame_count", 32'(frame_count), 32'd2);
    chk("recover_err_count", 32'(err_count), 32'd2);

    // SFD then DV low: empty frame
    preamble(7);
    idle(3);
    chk("empty_err_count", 32'(err_count), 32'd3);
    chk("empty_frame_count", 32'(frame_count), 32'd2);

    // enable low in IDLE ignores the whole frame
    enable = 1'b0;
    idle(1);
    preamble(7);
    tx(8'h44, 1'b0); tx(8'h45, 1'b0);
    idle(3);
    chk("disabled_frame_count", 32'(frame_count), 32'd2);
    chk("disabled_err_count", 32'(err_count), 32'd3);

    // enable dropped mid-DATA: frame still completes
    enable = 1'b1;
    idle(1);
    expect_beat(8'h11, 1'b0, 1'b0);
    expect_beat(8'h22, 1'b0, 1'b0);
    expect_beat(8'h33, 1'b1, 1'b0);
    preamble(7);
    tx(8'h11, 1'b0);
    enable = 1'b0;
    tx(8'h22, 1'b0); tx(8'h33, 1'b0);
    idle(4);
    chk("middrop_frame_count", 32'(frame_count), 32'd3);
    enable = 1'b1;

    // err_count saturation: start near the top, then pile on errors
    force dut.err_count_q = 16'hFFF0;
    idle(2);
    release dut.err_count_q;
    idle(1);
    for (int i = 0; i < 20; i++) begin
      tx(8'h00, 1'b0);
      idle(1);
    end
    idle(2);
    chk("sat_err_count", 32'(err_count), 32'hFFFF);
    preamble(7);
    idle(3);
    chk("sat_empty_err_count", 32'(err_count), 32'hFFFF);
    chk("sat_frame_count", 32'(frame_count), 32'd3);

    // frame_count wraps
    force dut.frame_count_q = 16'hFFFF;
    idle(2);
    release dut.frame_count_q;
    idle(1);
    expect_beat(8'h77, 1'b1, 1'b0);
    preamble(7);
    tx(8'h77, 1'b0);
    idle(4);
    chk("wrap_frame_count", 32'(frame_count), 32'd0);

    // Reset mid-frame discards the held byte
    preamble(7);
    tx(8'h99, 1'b0);
    reset_n = 1'b0;
    idle(2);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_iddr_rst", 32'(iddr_rst), 32'd1);
    chk("midrst_counts", 32'({frame_count, err_count}), 32'd0);
    reset_n = 1'b1;
    idle(18);
    chk("midrst_iddr_ce", 32'(iddr_ce), 32'd1);
    expect_beat(8'hC3, 1'b0, 1'b0);
    expect_beat(8'h3C, 1'b1, 1'b0);
    preamble(7);
    tx(8'hC3, 1'b0); tx(8'h3C, 1'b0);
    idle(4);
    chk("post_rst_frame_count", 32'(frame_count), 32'd1);
    chk("post_rst_err_count", 32'(err_count), 32'd0);

    idle(3);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rgmii_rx_ctrl.md
RGMII_RX_CTRL -- requirements
Module: rgmii_rx_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 16: number of cycles iddr_rst is held high after reset release.
REQ-002 Parameter MAX_PREAMBLE, default 7: maximum count of 0x55 bytes accepted before SFD.
REQ-003 clock  in  1  single clock, the IDDR C domain; all logic is rising-edge.
REQ-004 reset_n  in  1  asynchronous, active-low reset.
REQ-005 enable  in  1  frame acceptance enable, sampled only in IDLE.
REQ-006 q1  in  5  IDDR Q1, {rx_ctl_rise, rxd_rise[3:0]}, SAME_EDGE_PIPELINED.
REQ-007 q2  in  5  IDDR Q2, {rx_ctl_fall, rxd_fall[3:0]}.
REQ-008 iddr_rst  out  1  drives IDDR R.
REQ-009 iddr_ce  out  1  drives IDDR CE.
REQ-010 m_data  out  8  received byte.
REQ-011 m_valid  out  1  m_data valid for one cycle; no backpressure.
REQ-012 m_last  out  1  final byte of frame, qualified by m_valid.
REQ-013 m_error  out  1  frame bad, qualified by m_valid & m_last.
REQ-014 frame_count  out  16  good frames, wrapping.
REQ-015 err_count  out  16  bad or dropped frames, saturating at 0xFFFF.

Function
REQ-016 Decode per cycle: dv = q1[4]; er = q1[4] ^ q2[4]; byte = {q2[3:0], q1[3:0]}.
REQ-017 States: HOLD, IDLE, PREAMBLE, DATA, DROP; HOLD is entered on reset.
REQ-018 HOLD: iddr_rst=1, iddr_ce=0 for RST_CYCLES cycles, then IDLE; outside HOLD: iddr_rst=0, iddr_ce=1.
REQ-019 IDLE: if enable & dv & byte==0x55, go to PREAMBLE with pcnt=1; if enable & dv & any other byte, go to DROP and increment err_count; if !enable or !dv, stay.
REQ-020 PREAMBLE transitions:
- dv & 0x55 & pcnt<MAX_PREAMBLE: stay, pcnt++.
- dv & 0xD5: go to DATA, clear sticky error.
- !dv: go to IDLE, no count.
- any other dv byte, including 0x55 when pcnt==MAX_PREAMBLE: go to DROP and increment err_count.
REQ-021 DATA, dv: the byte is written to a one-byte hold register; if the hold register was already full, its old byte is emitted (m_valid=1, m_last=0); er sets the sticky error.
REQ-022 DATA, !dv with hold full: emit the held byte with m_last=1 and m_error=sticky; increment frame_count if the frame is good, otherwise err_count; go to IDLE.
REQ-023 DATA, !dv with hold empty (zero-length frame): no output, err_count++, go to IDLE.
REQ-024 DROP: stay until !dv, then go to IDLE; no output is produced.
REQ-025 Latency: a byte presented on q1/q2 in cycle t is emitted registered in cycle t+2 when the next byte or dv=0 arrives in cycle t+1; m_valid is never asserted on consecutive frames' bytes without at least one idle cycle between them.
REQ-026 All outputs are registered; m_valid, m_last and m_error are zero whenever not emitting.
REQ-027 err_count holds at 0xFFFF; frame_count wraps from 0xFFFF to 0x0000.
REQ-028 enable deasserted mid-frame has no effect until the state returns to IDLE.

Reset
REQ-029 reset_n low asynchronously forces:
- state HOLD, hold counter=0, iddr_rst=1, iddr_ce=0;
- m_data=0, m_valid=0, m_last=0, m_error=0;
- frame_count=0, err_count=0, hold register empty, sticky error=0.
REQ-030 Reset asserted mid-frame discards the frame without emitting m_last; after reset_n rises, RST_CYCLES cycles pass before any frame is accepted.

Verification
REQ-031 After reset release: iddr_rst=1 for exactly 16 cycles, then iddr_ce=1; a frame driven during HOLD produces no output.
REQ-032 Good frame 7x0x55, 0xD5, data 0x01 0x02 0x03, then dv=0: m_data emits 01, 02, 03 with m_last only on 03 and m_error=0; frame_count=1.
REQ-033 The same frame with er=1 on byte 0x02: the 03 beat has m_last=1 and m_error=1; err_count=1; frame_count is unchanged.
REQ-034 Bad preamble: 8x0x55 followed by 0xD5 (MAX_PREAMBLE=7) gives DROP, no m_valid, err_count+1; a subsequent good frame is received correctly.
REQ-035 SFD followed immediately by dv=0 gives no m_valid and err_count+1; with err_count preloaded to 0xFFFF via repeated errors, it stays 0xFFFF.
REQ-036 enable=0 in IDLE: a frame is ignored with no count change; enable dropped mid-DATA: the current frame completes normally.
